// File: rtl/series_adder_axis_collector.sv
// Packs M-word AXI-Stream frames into one M*W-bit vector for the series adder,
// dropping frames whose length disagrees with tlast.
module series_adder_axis_collector #(
    parameter int unsigned M  = 8,
    parameter int unsigned W  = 32,
    parameter int unsigned CW = 16
) (
    input  logic           clk,
    input  logic           rst_p,
    input  logic [W-1:0]   s_axis_tdata,
    input  logic           s_axis_tvalid,
    output logic           s_axis_tready,
    input  logic           s_axis_tlast,
    output logic [M*W-1:0] data_o,
    output logic           data_vld,
    input  logic           data_rdy,
    output logic           frame_err,
    output logic [CW-1:0]  frame_cnt,
    output logic [CW-1:0]  err_cnt
);
    localparam int unsigned CNTW = $clog2(M);
    localparam int unsigned FW   = M * W;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(M - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PEND    = 2'd1,
        DROP    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [FW-1:0]   buf_q, buf_d;
    logic [FW-1:0]   data_q, data_d;
    logic            vld_q, vld_d;
    logic            err_q, err_d;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic [CW-1:0]   ecnt_q, ecnt_d;
    logic [CW-1:0]   ecnt_sat_inc;
    logic            beat;

    assign s_axis_tready = (state_q != PEND);
    assign data_o        = data_q;
    assign data_vld      = vld_q;
    assign frame_err     = err_q;
    assign frame_cnt     = fcnt_q;
    assign err_cnt       = ecnt_q;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        data_d       = data_q;
        vld_d        = 1'b0;
        err_d        = 1'b0;
        fcnt_d       = fcnt_q;
        ecnt_d       = ecnt_q;
        beat         = s_axis_tvalid && s_axis_tready;
        ecnt_sat_inc = (ecnt_q == '1) ? ecnt_q : ecnt_q + CW'(1);

        unique case (state_q)
            COLLECT: begin
                if (beat) begin
                    for (int unsigned k = 0; k < M; k++) begin
                        if (cnt_q == CNTW'(k)) buf_d[k*W +: W] = s_axis_tdata;
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (s_axis_tlast) begin
                            state_d = PEND;
                        end else begin
                            // Overlong frame: flag once, then swallow the rest up to tlast
                            state_d = DROP;
                            err_d   = 1'b1;
                            ecnt_d  = ecnt_sat_inc;
                        end
                    end else if (s_axis_tlast) begin
                        cnt_d  = '0;
                        err_d  = 1'b1;
                        ecnt_d = ecnt_sat_inc;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            PEND: begin
                if (data_rdy) begin
                    data_d  = buf_q;
                    vld_d   = 1'b1;
                    fcnt_d  = fcnt_q + CW'(1);
                    state_d = COLLECT;
                end
            end
            DROP: begin
                if (beat && s_axis_tlast) state_d = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end
endmodule

// File: tb/tb_series_adder_axis_collector.sv
// Directed and randomized bench for series_adder_axis_collector against a
// frame-list reference model.
module tb_series_adder_axis_collector;
    localparam int unsigned M  = 8;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned FW = M * W;

    logic          clk = 1'b0;
    logic          rst_p;
    logic [W-1:0]  tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [FW-1:0] data_o;
    logic          data_vld;
    logic          data_rdy;
    logic          frame_err;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;

    series_adder_axis_collector #(.M(M), .W(W), .CW(CW)) dut (
        .clk           (clk),
        .rst_p         (rst_p),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .data_o        (data_o),
        .data_vld      (data_vld),
        .data_rdy      (data_rdy),
        .frame_err     (frame_err),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records issued frames and pulse events just after each edge
    logic [FW-1:0] got_q[$];
    int            got_cyc_q[$];
    int            err_pulse_n = 0;
    int            overlap_n   = 0;
    int            stable_viol = 0;
    logic [FW-1:0] held;
    always @(posedge clk) begin
        #1;
        if (rst_p) begin
            held = '0;
        end else begin
            if (data_vld) begin
                got_q.push_back(data_o);
                got_cyc_q.push_back(cyc);
                held = data_o;
            end else if (data_o !== held) begin
                stable_viol++;
            end
            if (frame_err) err_pulse_n++;
            if (frame_err && data_vld) overlap_n++;
        end
    end

    // Reference model state
    logic [W-1:0]  cur_q[$];
    logic [FW-1:0] exp_q[$];
    bit            dropping;
    logic [CW-1:0] exp_fc;
    logic [CW-1:0] exp_ec;
    int            exp_pulses;
    int            rd_ptr;
    int            err_base;
    int            beat_cyc;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_seq(input int base);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < M; k++) f[k*W +: W] = W'(base + k);
        return f;
    endfunction

    task automatic model_error();
        exp_pulses++;
        if (exp_ec != '1) exp_ec = exp_ec + CW'(1);
    endtask

    task automatic model_beat(input logic [W-1:0] d, input logic last);
        logic [FW-1:0] f;
        if (dropping) begin
            if (last) dropping = 1'b0;
        end else begin
            cur_q.push_back(d);
            if (cur_q.size() == M) begin
                if (last) begin
                    f = '0;
                    for (int k = 0; k < M; k++) f[k*W +: W] = cur_q[k];
                    exp_q.push_back(f);
                    exp_fc = exp_fc + CW'(1);
                end else begin
                    model_error();
                    dropping = 1'b1;
                end
                cur_q.delete();
            end else if (last) begin
                model_error();
                cur_q.delete();
            end
        end
    endtask

    task automatic model_reset();
        cur_q.delete();
        exp_q.delete();
        dropping   = 1'b0;
        exp_fc     = '0;
        exp_ec     = '0;
        exp_pulses = 0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        while (!tready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("tready_wait", FW'(tready), FW'(1));
        @(posedge clk);
        beat_cyc = cyc;
        model_beat(d, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic send_seq(input int base, input int len, input int gap);
        for (int i = 0; i < len; i++) begin
            send(W'(base + i), (i == len - 1));
            if (gap > 0) idle(gap);
        end
        idle(1);
    endtask

    task automatic send_rand(input int len);
        for (int i = 0; i < len; i++) begin
            send($urandom, (i == len - 1));
            idle($urandom_range(0, 2));
        end
        idle(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_p  = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(posedge clk);
        #2;
        check("rst_data_o", data_o, '0);
        check("rst_data_vld", FW'(data_vld), '0);
        check("rst_frame_err", FW'(frame_err), '0);
        check("rst_frame_cnt", FW'(frame_cnt), '0);
        check("rst_err_cnt", FW'(err_cnt), '0);
        check("rst_tready", FW'(tready), FW'(1));
        @(negedge clk);
        rst_p = 1'b0;
        model_reset();
        rd_ptr   = got_q.size();
        err_base = err_pulse_n;
    endtask

    task automatic check_frames(input string tag);
        int n;
        n = got_q.size() - rd_ptr;
        check({tag, "_nframes"}, FW'(n), FW'(exp_q.size()));
        if (n > exp_q.size()) n = exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_frame"}, got_q[rd_ptr + i], exp_q[i]);
        rd_ptr = got_q.size();
        exp_q.delete();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_cnt"}, FW'(frame_cnt), FW'(exp_fc));
        check({tag, "_err_cnt"}, FW'(err_cnt), FW'(exp_ec));
        check({tag, "_err_pulses"}, FW'(err_pulse_n - err_base), FW'(exp_pulses));
        check({tag, "_vld_err_overlap"}, FW'(overlap_n), '0);
        check({tag, "_data_o_stable"}, FW'(stable_viol), '0);
    endtask

    initial begin
        int first_vld;
        int pulses_before;
        rst_p    = 1'b1;
        tvalid   = 1'b0;
        tlast    = 1'b0;
        tdata    = '0;
        data_rdy = 1'b1;
        rd_ptr   = 0;
        err_base = 0;
        model_reset();
        do_reset();

        // Basic frame, latency from last beat to data_vld
        first_vld = got_q.size();
        send_seq(1, M, 0);
        idle(4);
        check("s1_nvld", FW'(got_q.size() - first_vld), FW'(1));
        if (got_q.size() > first_vld)
            check("s1_latency", FW'(got_cyc_q[first_vld]), FW'(beat_cyc + 2));
        check("s1_word_k", got_q[got_q.size() - 1], pack_seq(1));
        check_frames("s1");
        check_counts("s1");

        // Back-pressure from the adder holds the frame in PEND
        @(negedge clk);
        data_rdy = 1'b0;
        send_seq(101, M, 0);
        for (int i = 0; i < 20; i++) begin
            check("s2_tready_low", FW'(tready), '0);
            check("s2_vld_low", FW'(data_vld), '0);
            check("s2_data_hold", data_o, pack_seq(1));
            @(negedge clk);
        end
        data_rdy = 1'b1;
        @(posedge clk);
        #2;
        check("s2_vld_after_rdy", FW'(data_vld), FW'(1));
        check("s2_data_new", data_o, pack_seq(101));
        idle(2);
        check_frames("s2");
        check_counts("s2");

        // Short frame then good frame
        send_seq(50, 3, 0);
        send_seq(10, M, 0);
        idle(4);
        check("s3_good_frame", got_q[got_q.size() - 1], pack_seq(10));
        check_frames("s3");
        check_counts("s3");

        // Long frame: error right after word M, extra words dropped
        pulses_before = err_pulse_n;
        for (int i = 0; i < M; i++) send(W'(60 + i), 1'b0);
        #2;
        check("s4_err_after_word_m", FW'(err_pulse_n - pulses_before), FW'(1));
        send(W'(68), 1'b0);
        send(W'(69), 1'b1);
        idle(1);
        send_seq(70, M, 0);
        idle(4);
        check("s4_good_frame", got_q[got_q.size() - 1], pack_seq(70));
        check_frames("s4");
        check_counts("s4");

        // tvalid toggling every cycle
        first_vld = got_q.size();
        send_seq(1, M, 1);
        idle(4);
        check("s5_nvld", FW'(got_q.size() - first_vld), FW'(1));
        check("s5_frame", data_o, pack_seq(1));
        check_frames("s5");
        check_counts("s5");

        // Reset mid-frame discards partial words
        for (int i = 0; i < 5; i++) send(W'(90 + i), 1'b0);
        do_reset();
        send_seq(21, M, 0);
        idle(4);
        check("s6_frame", data_o, pack_seq(21));
        check("s6_frame_cnt_one", FW'(frame_cnt), FW'(1));
        check_frames("s6");
        check_counts("s6");

        // Random lengths, data, gaps and adder stalls; frame_cnt wraps at 2^CW
        for (int f = 0; f < 60; f++) begin
            int r;
            int len;
            r = $urandom_range(0, 9);
            if (r < 7)       len = M;
            else if (r == 7) len = $urandom_range(1, M - 1);
            else             len = $urandom_range(M + 1, M + 3);
            send_rand(len);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                data_rdy = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                data_rdy = 1'b1;
            end
        end
        idle(10);
        check_frames("rnd");
        check_counts("rnd");

        // Enough short frames to saturate err_cnt
        for (int f = 0; f < 18; f++) send_rand($urandom_range(1, M - 1));
        idle(4);
        check("sat_err_cnt", FW'(err_cnt), FW'({CW{1'b1}}));
        check_counts("sat");
        send_seq(200, M, 0);
        idle(4);
        check_frames("post_sat");
        check_counts("post_sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
